// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Owns the single GPR write port. In-order pipeline writeback (port A) and
//   long-latency results (port B: mul/div, load refill) compete for it. B
//   results wait in a B_DEPTH-entry FIFO. A normally wins, and a starvation
//   counter forces a stall so that the B head eventually drains.
//
//   Optional feature macro: GPR_WB_BYPASS_EN. When it is defined, an empty
//   FIFO with no A grant writes a valid B request straight to the GPR port
//   (1-edge latency, no enqueue). When it is undefined, every B request goes
//   through the FIFO.
//
// Ports
//   clk, reset                  posedge clock, asynchronous active-high reset
//   a_valid/a_addr/a_data/a_be  pipeline writeback (no backpressure)
//   b_valid/b_ready             long-latency handshake
//   b_addr/b_data/b_be          long-latency payload
//   rs_addr, rt_addr            decode source addresses
//   rs_pending, rt_pending      combinational hit on a valid FIFO entry (addr != 0)
//   stall_o                     registered; pipeline must hold a_valid=0 in this cycle
//   wr_o/wr_addr_o/wr_data_o/wr_be_o  registered GPR write (commits at next negedge)
//   b_count                     FIFO occupancy
//   err_o                       sticky: a_valid seen while stall_o=1
//
// Handshake: a B transfer happens at a posedge where b_valid && b_ready.
// b_ready depends only on the registered occupancy, never on b_valid. A null
// request (addr==0 or be==0) still completes the handshake but is dropped.
module gpr_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int B_DEPTH      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [ADDR_WIDTH-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic [DATA_WIDTH/8-1:0]       a_be,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0]         b_data,
  input  logic [DATA_WIDTH/8-1:0]       b_be,
  input  logic [ADDR_WIDTH-1:0]         rs_addr,
  input  logic [ADDR_WIDTH-1:0]         rt_addr,
  output logic                          rs_pending,
  output logic                          rt_pending,
  output logic                          stall_o,
  output logic                          wr_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic [DATA_WIDTH/8-1:0]       wr_be_o,
  output logic [$clog2(B_DEPTH):0]      b_count,
  output logic                          err_o
);

  localparam int PTR_W = $clog2(B_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(B_DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
  } entry_t;

  entry_t mem_q [B_DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d, err_q, err_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       wbe_q, wbe_d;

  logic   a_ok, b_ok, empty, full, pop, push, bypass, loss;
  entry_t head;
  logic [B_DEPTH-1:0] slot_vld;

  assign a_ok  = a_valid && (a_addr != '0) && (a_be != '0);
  assign b_ok  = b_valid && (b_addr != '0) && (b_be != '0);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = mem_q[rd_ptr_q];

`ifdef GPR_WB_BYPASS_EN
  assign b_ready = !full || empty;
  assign bypass  = !a_ok && empty && b_ok;
`else
  assign b_ready = !full;
  assign bypass  = 1'b0;
`endif

  // A always wins. Otherwise the FIFO head is popped. A B request taken on
  // the bypass path is never also enqueued.
  assign pop  = !a_ok && !empty;
  assign push = b_valid && b_ready && b_ok && !bypass;
  assign loss = a_ok && !empty;

  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  // The age counter saturates at STARVE_LIMIT-1. Each further loss at that
  // level asserts stall_o again.
  assign age_d   = loss ? ((age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1)) : '0;
  assign stall_d = loss && (age_q == AGE_MAX);
  assign err_d   = err_q || (a_valid && stall_q);

  always_comb begin
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    if (a_ok) begin
      wr_d = 1'b1; waddr_d = a_addr; wdata_d = a_data; wbe_d = a_be;
    end else if (pop) begin
      wr_d = 1'b1; waddr_d = head.addr; wdata_d = head.data; wbe_d = head.be;
    end else if (bypass) begin
      wr_d = 1'b1; waddr_d = b_addr; wdata_d = b_data; wbe_d = b_be;
    end
  end

  // A slot is valid when its distance from the read pointer is less than
  // the occupancy. An entry that is popped has already left by the next cycle.
  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < B_DEPTH; i++) begin
      slot_vld[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
    end
  end

  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int i = 0; i < B_DEPTH; i++) begin
      if (slot_vld[i] && (rs_addr != '0) && (mem_q[i].addr == rs_addr)) rs_pending = 1'b1;
      if (slot_vld[i] && (rt_addr != '0) && (mem_q[i].addr == rt_addr)) rt_pending = 1'b1;
    end
  end

  // The storage array has no reset. An entry becomes visible only through count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: b_addr, data: b_data, be: b_be};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wbe_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wbe_q    <= wbe_d;
    end
  end

  assign stall_o   = stall_q;
  assign err_o     = err_q;
  assign wr_o      = wr_q;
  assign wr_addr_o = waddr_q;
  assign wr_data_o = wdata_q;
  assign wr_be_o   = wbe_q;
  assign b_count   = count_q;

endmodule
